// File: rtl/shift_arb_pkg.sv
//------------------------------------------------------------------------------
// Module   : shift_arb_pkg
// Purpose  : Shared types and sizing helpers for the shift_arb_ctrl slice.
//            - state_t     : sequencer state encoding (IDLE, SHIFT, DONE)
//            - cnt_width   : bit-counter width for a given word width
//            - grant_width : grant index width for a given requester count
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package shift_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Counter must be able to hold p_nbits itself.
  function automatic int cnt_width(input int nbits);
    return $clog2(nbits + 1);
  endfunction

  // A single requester still needs a 1-bit grant index.
  function automatic int grant_width(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/shift_reg_core.sv
//------------------------------------------------------------------------------
// Module   : shift_reg_core
// Purpose  : Parallel-load, left-shifting shift register.
//            Load has priority over shift; shift is {q[p_nbits-2:0], d}.
// Ports    : clk     - clock
//            reset   - synchronous active-high reset (fills with p_reset_value)
//            d       - serial input
//            en      - shift enable
//            load    - parallel load word
//            load_en - parallel load enable
//            q       - register contents
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module shift_reg_core #(
  parameter int   p_nbits       = 8,
  parameter logic p_reset_value = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               d,
  input  logic               en,
  input  logic [p_nbits-1:0] load,
  input  logic               load_en,
  output logic [p_nbits-1:0] q
);

  logic [p_nbits-1:0] r_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= {p_nbits{p_reset_value}};
    end else if (load_en) begin
      r_q <= load;
    end else if (en) begin
      r_q <= {r_q[p_nbits-2:0], d};
    end
  end

  assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/shift_arb_ctrl.sv
//------------------------------------------------------------------------------
// Module   : shift_arb_ctrl
// Purpose  : Round-robin arbitrating serializer. Accepts a parallel word from
//            one of p_nreq requesters, loads it into shift_reg_core and
//            streams it out one bit per accepted cycle.
// Ports    : clk, reset          - clock, synchronous active-high reset
//            req_valid/req_ready - per-requester handshake (ready is one-hot)
//            req_data            - requester i word at [i*p_nbits +: p_nbits]
//            ser_out/ser_valid   - serial bit and its valid
//            ser_ready           - downstream accepts ser_out
//            busy                - word in flight (SHIFT or DONE)
//            done                - one-cycle pulse after the last bit
//            grant_id            - index of the last granted requester
// Config   : SHIFT_ARB_LSB_FIRST_EN - when defined the selected word is
//            bit-reversed before load so bit 0 is serialized first.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module shift_arb_ctrl
  import shift_arb_pkg::*;
#(
  parameter int   p_nbits       = 8,
  parameter int   p_nreq        = 2,
  parameter logic p_reset_value = 1'b0
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [p_nreq-1:0]                 req_valid,
  input  logic [p_nreq*p_nbits-1:0]         req_data,
  output logic [p_nreq-1:0]                 req_ready,
  output logic                              ser_out,
  output logic                              ser_valid,
  input  logic                              ser_ready,
  output logic                              busy,
  output logic                              done,
  output logic [grant_width(p_nreq)-1:0]    grant_id
);

  localparam int c_cw = cnt_width(p_nbits);
  localparam int c_gw = grant_width(p_nreq);
  localparam logic [c_cw-1:0] c_last = c_cw'(p_nbits - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_gw-1:0]    r_rr_ptr;
  logic [c_gw-1:0]    r_grant_id;
  logic [c_cw-1:0]    r_cnt;

  logic               w_any;
  logic [c_gw-1:0]    w_sel;
  int                 w_idx;
  logic               w_grant_ok;
  logic               w_xfer;
  logic               w_accept;
  logic [p_nbits-1:0] w_sel_word;
  logic [p_nbits-1:0] w_load_word;
  logic [p_nbits-1:0] w_q;

  // Round-robin search: first valid requester at or after r_rr_ptr, wrapping.
  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    w_idx = 0;
    for (int k = 0; k < p_nreq; k++) begin
      w_idx = (int'(r_rr_ptr) + k) % p_nreq;
      if (!w_any && req_valid[w_idx]) begin
        w_any = 1'b1;
        w_sel = w_idx[c_gw-1:0];
      end
    end
  end

  assign w_grant_ok = (r_state == ST_IDLE) && !reset && w_any;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < p_nreq; i++) begin
      req_ready[i] = w_grant_ok && (int'(w_sel) == i);
    end
  end

  assign w_xfer     = |(req_valid & req_ready);
  assign w_sel_word = req_data[int'(w_sel)*p_nbits +: p_nbits];

`ifdef SHIFT_ARB_LSB_FIRST_EN
  // Reverse so the left shift emits original bit 0 first.
  for (genvar i = 0; i < p_nbits; i++) begin : g_rev
    assign w_load_word[i] = w_sel_word[p_nbits-1-i];
  end
`else
  assign w_load_word = w_sel_word;
`endif

  assign ser_valid = (r_state == ST_SHIFT);
  assign w_accept  = ser_valid && ser_ready;

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_xfer) w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (w_accept && (r_cnt == c_last)) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
      r_cnt      <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_xfer) begin
        r_grant_id <= w_sel;
        r_rr_ptr   <= (int'(w_sel) == p_nreq - 1) ? '0 : w_sel + 1'b1;
        r_cnt      <= '0;
      end else if (w_accept) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  shift_reg_core #(
    .p_nbits       (p_nbits),
    .p_reset_value (p_reset_value)
  ) u_shift_reg_core (
    .clk     (clk),
    .reset   (reset),
    .d       (p_reset_value),
    .en      (w_accept),
    .load    (w_load_word),
    .load_en (w_xfer),
    .q       (w_q)
  );

  assign ser_out  = w_q[p_nbits-1];
  assign done     = (r_state == ST_DONE);
  assign busy     = (r_state != ST_IDLE);
  assign grant_id = r_grant_id;

endmodule

`default_nettype wire

// File: doc/shift_arb_ctrl.md
# shift_arb_ctrl

Arbitrating sequencer for a parallel-load, left-shifting shift register used as a serializer. Accepts parallel words from `p_nreq` requesters through valid/ready handshakes and selects one by round-robin. Loads the word into an internal shift register and streams it out one bit per accepted cycle under downstream backpressure. It sits between word-producing blocks and a single shared serial link.

## Interface
- `p_nbits`, 8, word width; must be ≥ 2.
- `p_nreq`, 2, number of requesters; must be ≥ 1.
- `p_reset_value`, 1'b0, fill value of the shift register on reset.

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  p_nreq  per-requester word valid.
- `req_data`  in  p_nreq*p_nbits  requester i's word at bits `[i*p_nbits +: p_nbits]`.
- `req_ready`  out  p_nreq  one-hot grant/accept.
- `ser_out`  out  1  current serial bit.
- `ser_valid`  out  1  `ser_out` is valid.
- `ser_ready`  in  1  downstream accepts `ser_out` this cycle.
- `busy`  out  1  a word is in flight (SHIFT or DONE).
- `done`  out  1  one-cycle pulse after the last bit of a word is accepted.
- `grant_id`  out  $clog2(p_nreq) (min 1)  index of the last granted requester.

## Operation
- FSM states and transitions:
  - IDLE → SHIFT on a word transfer.
  - SHIFT → DONE on acceptance of bit `p_nbits`.
  - DONE → IDLE unconditionally after one cycle.
- Arbitration, IDLE only:
  - Grant the first requester with `req_valid` high, searching upward with wrap from `rr_ptr`.
  - `req_ready` is combinational, asserted only for that requester, and zero outside IDLE or while `reset` is high.
  - Transfer = `req_valid[g] & req_ready[g]`.
  - On transfer: `grant_id <= g`, `rr_ptr <= (g+1) mod p_nreq`, `load_en` to the shift register, bit counter cleared.
- SHIFT:
  - `ser_valid = 1`, `ser_out = q[p_nbits-1]`.
  - On `ser_valid & ser_ready`: shift enable pulses with serial-in `d = p_reset_value`, and the counter increments.
  - If `ser_ready` is low, `q` and the counter hold.
- Counter width is `$clog2(p_nbits+1)`. The transition to DONE occurs when an accept happens with the counter at `p_nbits-1`.
- DONE: `done = 1`, `ser_valid = 0`, `req_ready = 0`. Requests are not accepted in this cycle.
- `busy` = state is SHIFT or DONE.
- Reset values: state IDLE, `rr_ptr` 0, counter 0, `q` all `p_reset_value`, `grant_id` 0, `ser_valid`/`done`/`busy`/`req_ready` 0, `ser_out` = `p_reset_value`.
- Reset mid-word: the word is dropped with no `done`. The first cycle after reset deasserts is IDLE.
- Simultaneous valid on all requesters: strict round-robin with no starvation. Each requester waits at most `p_nreq-1` words.
- A requester dropping `req_valid` before it is granted is legal. No word is lost once transferred.

## Timing
- Transfer at edge T → first bit valid in cycle T+1.
- With `ser_ready` held high:
  - Bits appear in cycles T+1…T+p_nbits.
  - `done` is high in cycle T+p_nbits+1.
  - The next grant is possible in cycle T+p_nbits+2.
- Minimum word period is `p_nbits+2` cycles. Each low-`ser_ready` cycle in SHIFT adds one cycle.
- `req_ready` depends combinationally on `req_valid`. `ser_valid` and `ser_out` are register-driven.

## Configuration
- `SHIFT_ARB_LSB_FIRST_EN`:
  - Defined: the selected word is bit-reversed before load, so bit 0 is serialized first.
  - Undefined: the word loads as-is and is serialized MSB first.
  - Handshake timing is identical in both cases.

## Structure
- Package `shift_arb_pkg` holds:
  - the state enum typedef (IDLE, SHIFT, DONE);
  - the counter-width and grant-width helper constants.
- Sub-module `shift_reg_core` is the parallel-load shift register.
  - Ports: `clk`, `reset`, `d`, `en`, `load`, `load_en`, `q`.
  - Behaviour: synchronous reset to `p_reset_value`; load has priority over shift; shift is `{q[p_nbits-2:0], d}`.
- Arbiter, FSM and counter live in `shift_arb_ctrl`.

## Test plan
- Single word:
  - Stimulus: `req_valid=2'b01`, data 0xC1, `ser_ready=1`.
  - Response: `req_ready=2'b01` in cycle T; `ser_out` 1,1,0,0,0,0,0,1 in T+1…T+8; `done` in T+9; `grant_id=0`.
- Round-robin:
  - Stimulus: both requesters held valid with 0x0F and 0xF0.
  - Response: grants alternate 0,1,0,1; words appear back-to-back with a 2-cycle gap.
- Backpressure:
  - Stimulus: data 0xA5; `ser_ready` low for 3 cycles after bit 2.
  - Response: `ser_out` and `ser_valid` hold; the sequence is still 1,0,1,0,0,1,0,1; `done` slips 3 cycles.
- Reset mid-word:
  - Stimulus: `reset` pulsed after 3 bits are accepted.
  - Response: next cycle IDLE; `ser_valid=0`, `busy=0`, no `done`; `rr_ptr=0`, so requester 0 wins the next contention.
- LSB-first:
  - Stimulus: `SHIFT_ARB_LSB_FIRST_EN` defined, data 0x01.
  - Response: `ser_out` 1,0,0,0,0,0,0,0; without the macro the sequence is 0,0,0,0,0,0,0,1.
